// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for an in-order pipeline with NUM_STAGES registers
// (bit 0 = PC). Arbitrates memory freezes, load-use bubbles and branch
// redirects; a branch resolved during a freeze is held in pend_q and replayed
// as a flush in the first cycle after the freeze. Also provides a sticky stall
// watchdog and saturating stall/flush performance counters.
//
//  state  | meaning
//  -------+-----------------------------------------------------------------
//  pend_q | 0: no deferred redirect, 1: branch captured during freeze, not applied
module pipe_hazard_ctrl #(
    parameter int NUM_STAGES   = 5,
    parameter int HAZARD_STAGE = 2,
    parameter int BRANCH_STAGE = 2,
    parameter int TIMEOUT      = 1024,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  branch_req,
    input  logic                  dmem_busy,
    input  logic                  imem_busy,
    input  logic                  hazard_req,
    output logic [NUM_STAGES-1:0] stall,
    output logic [NUM_STAGES-1:0] flush,
    output logic                  flush_pending,
    output logic                  stall_timeout,
    output logic [CNT_WIDTH-1:0]  stall_count,
    output logic [CNT_WIDTH-1:0]  flush_count
);

    localparam int FC_W = $clog2(TIMEOUT + 1);
    localparam logic [FC_W-1:0] FC_MAX    = FC_W'(TIMEOUT);
    localparam logic [FC_W-1:0] FC_LAST   = FC_W'(TIMEOUT - 1);
    localparam logic [NUM_STAGES-1:0] ALL_ONES  = {NUM_STAGES{1'b1}};
    localparam logic [NUM_STAGES-1:0] BR_FLUSH  = ALL_ONES >> (NUM_STAGES - 1 - BRANCH_STAGE);
    localparam logic [NUM_STAGES-1:0] HZ_STALL  = ALL_ONES >> (NUM_STAGES - 1 - HAZARD_STAGE);
    localparam logic [NUM_STAGES-1:0] HZ_BUBBLE = NUM_STAGES'(1) << (HAZARD_STAGE + 1);

    generate
        if (NUM_STAGES < 3 || HAZARD_STAGE + 1 >= NUM_STAGES || BRANCH_STAGE >= NUM_STAGES) begin : g_bad_params
            $error("pipe_hazard_ctrl: illegal stage parameters");
        end
    endgenerate

    logic            freeze;
    logic            pend_q;
    logic [FC_W-1:0] freeze_cnt;

    assign freeze        = dmem_busy | imem_busy;
    assign flush_pending = pend_q;

    // Priority decision: freeze > branch (live or replayed) > load-use > idle.
    always_comb begin
        stall = '0;
        flush = '0;
        if (freeze) begin
            stall = ALL_ONES;
        end else if (branch_req | pend_q) begin
            // Any load-use hazard now belongs to a wrong-path instruction.
            flush = BR_FLUSH;
        end else if (hazard_req) begin
            stall = HZ_STALL;
            flush = HZ_BUBBLE;
        end
    end

    // Deferred redirect: held across the freeze, consumed by the first free cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q <= 1'b0;
        end else if (freeze) begin
            pend_q <= pend_q | branch_req;
        end else begin
            pend_q <= 1'b0;
        end
    end

    // Watchdog: consecutive freeze cycles, saturating; timeout flag is sticky.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            freeze_cnt    <= '0;
            stall_timeout <= 1'b0;
        end else if (!freeze) begin
            freeze_cnt <= '0;
        end else if (freeze_cnt != FC_MAX) begin
            freeze_cnt <= freeze_cnt + FC_W'(1);
            if (freeze_cnt == FC_LAST) begin
                stall_timeout <= 1'b1;
            end
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if ((|stall) && (stall_count != {CNT_WIDTH{1'b1}})) begin
                stall_count <= stall_count + CNT_WIDTH'(1);
            end
            if (flush[0] && (flush_count != {CNT_WIDTH{1'b1}})) begin
                flush_count <= flush_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule
